apb_2_axi_lite: RTL and testbench
=================================

Name: apb_2_axi_lite

Overview:
APB4 completer to AXI4-Lite manager bridge. Each APB transfer becomes exactly one AXI-Lite single-beat write or read. PREADY is held low until the AXI response returns. Used where an APB-only host must reach AXI-Lite register banks; it is the counterpart of the existing AXI-Lite to APB bridge.

Parameters:
AXI_DATA_WIDTH, 32, data width on both buses (multiple of 8)
AXI_ADDR_WIDTH, 4, address width on both buses
TIMEOUT_CYCLES, 255, AXI wait limit in cycles; used only with APB2AXI_TIMEOUT_EN

Ports:
M_AXI_ACLK  in  1  single clock for both buses
M_AXI_ARESETN  in  1  asynchronous active-low reset
PADDR  in  AXI_ADDR_WIDTH  APB address
PPROT  in  3  APB protection
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write 0=read
PWDATA  in  AXI_DATA_WIDTH  write data
PSTRB  in  AXI_DATA_WIDTH/8  byte strobes
PREADY  out  1  transfer complete
PRDATA  out  AXI_DATA_WIDTH  read data
PSLVERR  out  1  error response
M_AXI_AWADDR/AWPROT/AWVALID  out  AXI_ADDR_WIDTH/3/1  write address channel
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1  write data channel
M_AXI_WREADY  in  1
M_AXI_BRESP/BVALID  in  2/1  write response
M_AXI_BREADY  out  1
M_AXI_ARADDR/ARPROT/ARVALID  out  AXI_ADDR_WIDTH/3/1  read address channel
M_AXI_ARREADY  in  1
M_AXI_RDATA/RRESP/RVALID  in  AXI_DATA_WIDTH/2/1  read data channel
M_AXI_RREADY  out  1

Behaviour:
- Reset (async, active low): all outputs 0 immediately; FSM goes to IDLE. Reset mid-transfer drops every VALID/READY; no AXI handshake completes.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: on APB setup phase (PSEL && !PENABLE), latch PADDR, PPROT, PWDATA, PSTRB and PWRITE.
  - Write: go to WR_REQ; AWVALID=1 and WVALID=1 from the next cycle.
  - Read: go to RD_REQ; ARVALID=1 from the next cycle.
- WR_REQ: AW and W complete independently. Each VALID drops in the cycle after its own handshake; two done flags track completion. Once both are done, go to WR_RESP with BREADY=1.
- RD_REQ: after the AR handshake, drop ARVALID; go to RD_RESP with RREADY=1.
- Simultaneous events: AW and W handshakes in the same cycle are legal. A handshake in the first VALID cycle is legal. BVALID/RVALID arriving before the request state ends is simply held by the subordinate; BREADY/RREADY stay 0 until the request state exits.
- WR_RESP: on BVALID, drop BREADY; PSLVERR <= BRESP[1]; PREADY <= 1; go to DONE.
- RD_RESP: on RVALID, drop RREADY; PRDATA <= RDATA; PSLVERR <= RRESP[1]; PREADY <= 1; go to DONE.
- DONE: PREADY is high for exactly one cycle, then PREADY, PSLVERR and PRDATA return to 0; go to IDLE.
- PREADY is never 1 outside the access phase. A back-to-back setup phase arriving on the cycle after DONE is accepted.
- Minimum latency, setup to PREADY=1: write 3 cycles (AW/W at +1, B at +2, PREADY at +3); read 3 cycles.
- APB inputs are ignored outside IDLE. PSEL dropping mid-transfer is a protocol violation; the AXI transaction still completes.
- Response mapping: OKAY/EXOKAY give PSLVERR=0; SLVERR/DECERR give PSLVERR=1.

Optional Feature:
APB2AXI_TIMEOUT_EN
- Defined:
  - An 8..16-bit wait counter runs in the request and response states and clears on every handshake.
  - At TIMEOUT_CYCLES the APB transfer completes with PREADY=1, PSLVERR=1, PRDATA=0.
  - The FSM then enters an extra DRAIN state: it keeps pending VALIDs asserted and BREADY/RREADY=1 until every outstanding AXI handshake finishes, then returns to IDLE. New APB setups are not accepted during DRAIN.
- Undefined: no counter and no DRAIN state; the bridge waits indefinitely.

Decomposition:
- Package axi_apb_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - the state typedef apb2axi_state_t
- No sub-module is required. The timeout counter stays inline.

Test Plan:
- APB write 0x4 / 0xDEADBEEF / PSTRB 0xF with AWREADY=WREADY=BREADY-side immediate and BRESP=OKAY -> AWADDR=0x4, WDATA=0xDEADBEEF, PREADY=1 three cycles after setup, PSLVERR=0.
- APB read 0x8; subordinate returns RDATA=0x12345678 with ARREADY delayed 4 cycles -> PRDATA=0x12345678 with PREADY, latency 7.
- Write with WREADY 2 cycles before AWREADY, then BRESP=2'b10 -> each VALID drops independently, exactly one handshake per channel, PSLVERR=1.
- Read with RRESP=2'b11 -> PSLVERR=1; PRDATA returns to 0 the cycle after PREADY.
- Assert M_AXI_ARESETN=0 while AWVALID=1 -> all outputs 0 in the same cycle; the next APB write after reset works normally.
- (APB2AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16) with ARREADY held 0 -> PREADY=1/PSLVERR=1 at the timeout; ARVALID stays 1; the next setup stalls until ARREADY and RVALID complete.

Source files
------------

// File: rtl/axi_apb_pkg.sv
// Shared AXI response codes, response decode and bridge FSM state type for apb_2_axi_lite.
// The DRAIN state exists only when APB2AXI_TIMEOUT_EN is defined.
package axi_apb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
`ifdef APB2AXI_TIMEOUT_EN
        DONE    = 3'd5,
        DRAIN   = 3'd6
`else
        DONE    = 3'd5
`endif
    } apb2axi_state_t;

    // Maps an AXI response code onto the APB error flag.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   return 1'b0;
            RESP_SLVERR, RESP_DECERR: return 1'b1;
            default:                  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/apb_2_axi_lite.sv
// APB4 completer to AXI4-Lite manager bridge: one single-beat AXI access per APB transfer.
// Optional macro APB2AXI_TIMEOUT_EN adds a wait counter and a DRAIN state for stuck subordinates.
module apb_2_axi_lite
    import axi_apb_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]     PADDR,
    input  logic [2:0]                    PPROT,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AXI_DATA_WIDTH-1:0]     PWDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   PSTRB,
    output logic                          PREADY,
    output logic [AXI_DATA_WIDTH-1:0]     PRDATA,
    output logic                          PSLVERR,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    if ((AXI_DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("apb_2_axi_lite: unsupported parameter set");
    end

    apb2axi_state_t              r_state, w_state_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic [2:0]                  r_prot, w_prot_nxt;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0]           r_wstrb, w_wstrb_nxt;
    logic                        r_write, w_write_nxt;
    logic                        r_awvalid, w_awvalid_nxt;
    logic                        r_wvalid, w_wvalid_nxt;
    logic                        r_bready, w_bready_nxt;
    logic                        r_arvalid, w_arvalid_nxt;
    logic                        r_rready, w_rready_nxt;
    logic                        r_aw_done, w_aw_done_nxt;
    logic                        r_w_done, w_w_done_nxt;
    logic                        r_pready, w_pready_nxt;
    logic                        r_pslverr, w_pslverr_nxt;
    logic [AXI_DATA_WIDTH-1:0]   r_prdata, w_prdata_nxt;

    logic w_setup, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign w_setup = PSEL && !PENABLE;
    assign w_aw_hs = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs  = r_wvalid  && M_AXI_WREADY;
    assign w_b_hs  = r_bready  && M_AXI_BVALID;
    assign w_ar_hs = r_arvalid && M_AXI_ARREADY;
    assign w_r_hs  = r_rready  && M_AXI_RVALID;

`ifdef APB2AXI_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic             w_wait_busy, w_any_hs, w_timeout;

    // Wait counter: runs while an AXI request or response is outstanding, cleared by any handshake.
    assign w_wait_busy = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                         (r_state == RD_REQ) || (r_state == RD_RESP);
    assign w_any_hs    = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
    assign w_timeout   = w_wait_busy && !w_any_hs && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_wait_cnt_nxt = (!w_wait_busy || w_any_hs) ? '0 : r_wait_cnt + CNT_W'(1);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) r_wait_cnt <= '0;
        else                r_wait_cnt <= w_wait_cnt_nxt;
    end
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_prot    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_write   <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_prot    <= w_prot_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_write   <= w_write_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
        end
    end

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_prot_nxt    = r_prot;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_write_nxt   = r_write;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;

        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_addr_nxt  = PADDR;
                    w_prot_nxt  = PPROT;
                    w_wdata_nxt = PWDATA;
                    w_wstrb_nxt = PSTRB;
                    w_write_nxt = PWRITE;
                    if (PWRITE) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = WR_REQ;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_bready_nxt  = 1'b1;
                    w_state_nxt   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt  = 1'b0;
                    w_pslverr_nxt = resp_is_err(M_AXI_BRESP);
                    w_pready_nxt  = 1'b1;
                    w_state_nxt   = DONE;
                end
            end
            RD_REQ: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (w_r_hs) begin
                    w_rready_nxt  = 1'b0;
                    w_prdata_nxt  = M_AXI_RDATA;
                    w_pslverr_nxt = resp_is_err(M_AXI_RRESP);
                    w_pready_nxt  = 1'b1;
                    w_state_nxt   = DONE;
                end
            end
            DONE: begin
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
                w_prdata_nxt  = '0;
                w_state_nxt   = IDLE;
            end
`ifdef APB2AXI_TIMEOUT_EN
            // APB side already completed with an error; finish the AXI side before taking new work.
            DRAIN: begin
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
                if (w_aw_hs) w_awvalid_nxt = 1'b0;
                if (w_w_hs)  w_wvalid_nxt  = 1'b0;
                if (w_ar_hs) w_arvalid_nxt = 1'b0;
                if (w_b_hs || w_r_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_arvalid_nxt = 1'b0;
                    w_bready_nxt  = 1'b0;
                    w_rready_nxt  = 1'b0;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase

`ifdef APB2AXI_TIMEOUT_EN
        if (w_timeout) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
            w_prdata_nxt  = '0;
            w_bready_nxt  = r_write;
            w_rready_nxt  = !r_write;
            w_state_nxt   = DRAIN;
        end
`endif
    end

    assign PREADY        = r_pready;
    assign PRDATA        = r_prdata;
    assign PSLVERR       = r_pslverr;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = r_prot;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = r_prot;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_apb_2_axi_lite.sv
// Directed bench for apb_2_axi_lite: APB master task plus a delay-configurable AXI-Lite subordinate.
module tb_apb_2_axi_lite;

`ifdef APB2AXI_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk, rst_n;
    logic [3:0]  PADDR;
    logic [2:0]  PPROT;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;
    logic [31:0] PRDATA;
    logic [3:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    apb_2_axi_lite #(
        .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(4), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subordinate model: readies assert once VALID has waited the configured number of cycles.
    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = '0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_aw_only = 0;
    logic [3:0]  cap_awaddr = '0, cap_araddr = '0, cap_wstrb = '0;
    logic [2:0]  cap_awprot = '0;
    logic [31:0] cap_wdata = '0;

    assign AWREADY = AWVALID && (aw_wait >= aw_delay);
    assign WREADY  = WVALID  && (w_wait  >= w_delay);
    assign ARREADY = ARVALID && (ar_wait >= ar_delay);
    assign BVALID  = b_pend;
    assign BRESP   = bresp_v;
    assign RVALID  = r_pend;
    assign RRESP   = rresp_v;
    assign RDATA   = rdata_v;

    always @(posedge clk) begin : mon
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, awv, wv, arv;
        aw_hs = AWVALID && AWREADY;
        w_hs  = WVALID && WREADY;
        b_hs  = BVALID && BREADY;
        ar_hs = ARVALID && ARREADY;
        r_hs  = RVALID && RREADY;
        awv = AWVALID; wv = WVALID; arv = ARVALID;
        if (aw_hs) begin cap_awaddr = AWADDR; cap_awprot = AWPROT; end
        if (w_hs)  begin cap_wdata = WDATA; cap_wstrb = WSTRB; end
        if (ar_hs) cap_araddr = ARADDR;
        if (awv && !wv) n_aw_only++;
        #1;
        if (!rst_n) begin
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        end else begin
            if (aw_hs) begin n_aw++; aw_wait = 0; aw_got = 1'b1; end else if (awv) aw_wait++;
            if (w_hs)  begin n_w++;  w_wait = 0;  w_got = 1'b1;  end else if (wv)  w_wait++;
            if (b_hs)  begin n_b++;  b_pend = 1'b0; end
            if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; end
            if (ar_hs) begin n_ar++; ar_wait = 0; r_pend = 1'b1; end else if (arv) ar_wait++;
            if (r_hs)  begin n_r++;  r_pend = 1'b0; end
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer starting now; returns latency from setup, completion values and the next-cycle state.
    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output int lat, output logic [31:0] rdata, output logic err,
                            output logic post_ready, output logic [31:0] post_rdata);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; PPROT = prot;
        tick();
        PENABLE = 1'b1;
        lat = 1;
        while (!PREADY && lat < 60) begin
            tick();
            lat++;
        end
        rdata = PRDATA;
        err   = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        post_ready = PREADY;
        post_rdata = PRDATA;
    endtask

    function automatic logic any_out();
        return |{PREADY, PRDATA, PSLVERR, AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID,
                 BREADY, ARADDR, ARPROT, ARVALID, RREADY};
    endfunction

    int          lat, b_aw, b_w, b_b, b_ar, b_r, b_only;
    logic [31:0] rd, prd;
    logic        err, prdy;

    initial begin
        rst_n = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        repeat (3) tick();
        check("reset_outputs_zero", 32'(any_out()), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_outputs_zero", 32'(any_out()), 32'd0);

        // Write with immediate subordinate, OKAY response
        b_aw = n_aw; b_w = n_w; b_b = n_b;
        apb_xfer(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 3'b010, lat, rd, err, prdy, prd);
        check("wr1_latency", 32'(lat), 32'd3);
        check("wr1_pslverr", 32'(err), 32'd0);
        check("wr1_awaddr", 32'(cap_awaddr), 32'h4);
        check("wr1_awprot", 32'(cap_awprot), 32'h2);
        check("wr1_wdata", cap_wdata, 32'hDEADBEEF);
        check("wr1_wstrb", 32'(cap_wstrb), 32'hF);
        check("wr1_hs_count", 32'((n_aw - b_aw) + 10 * (n_w - b_w) + 100 * (n_b - b_b)), 32'd111);
        check("wr1_pready_one_cycle", 32'(prdy), 32'd0);

        // Back-to-back read, ARREADY 4 cycles late
        ar_delay = 4; rdata_v = 32'h12345678; rresp_v = 2'b00;
        b_ar = n_ar; b_r = n_r;
        apb_xfer(1'b0, 4'h8, 32'h0, 4'h0, 3'b000, lat, rd, err, prdy, prd);
        check("rd1_latency", 32'(lat), 32'd7);
        check("rd1_prdata", rd, 32'h12345678);
        check("rd1_pslverr", 32'(err), 32'd0);
        check("rd1_araddr", 32'(cap_araddr), 32'h8);
        check("rd1_hs_count", 32'((n_ar - b_ar) + 10 * (n_r - b_r)), 32'd11);
        check("rd1_prdata_cleared", prd, 32'd0);

        // Write where W completes two cycles before AW, SLVERR response
        aw_delay = 2; w_delay = 0; bresp_v = 2'b10;
        b_aw = n_aw; b_w = n_w; b_only = n_aw_only;
        apb_xfer(1'b1, 4'hC, 32'h0BADF00D, 4'h5, 3'b001, lat, rd, err, prdy, prd);
        check("wr2_latency", 32'(lat), 32'd5);
        check("wr2_pslverr", 32'(err), 32'd1);
        check("wr2_aw_only_cycles", 32'(n_aw_only - b_only), 32'd2);
        check("wr2_hs_count", 32'((n_aw - b_aw) + 10 * (n_w - b_w)), 32'd11);
        check("wr2_wstrb", 32'(cap_wstrb), 32'h5);

        // Read with DECERR
        aw_delay = 0; ar_delay = 0; rresp_v = 2'b11; rdata_v = 32'hCAFEF00D; bresp_v = 2'b00;
        apb_xfer(1'b0, 4'hA, 32'h0, 4'h0, 3'b000, lat, rd, err, prdy, prd);
        check("rd2_latency", 32'(lat), 32'd3);
        check("rd2_pslverr", 32'(err), 32'd1);
        check("rd2_prdata", rd, 32'hCAFEF00D);
        check("rd2_prdata_cleared", prd, 32'd0);
        check("rd2_pready_cleared", 32'(prdy), 32'd0);
        rresp_v = 2'b00;

        // Reset while AWVALID is high
        aw_delay = 100; w_delay = 100;
        b_aw = n_aw;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h6; PWDATA = 32'h11112222; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        check("rst_awvalid_before", 32'(AWVALID), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs_zero", 32'(any_out()), 32'd0);
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        rst_n = 1'b1;
        aw_delay = 0; w_delay = 0;
        tick();
        apb_xfer(1'b1, 4'h2, 32'h0000A5A5, 4'h3, 3'b000, lat, rd, err, prdy, prd);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_pslverr", 32'(err), 32'd0);
        check("post_rst_awaddr", 32'(cap_awaddr), 32'h2);
        check("post_rst_wdata", cap_wdata, 32'h0000A5A5);
        check("post_rst_aw_hs_count", 32'(n_aw - b_aw), 32'd1);

`ifdef APB2AXI_TIMEOUT_EN
        // Stuck AR channel: APB completes with error, AXI side drains before new work
        ar_delay = 1000;
        b_ar = n_ar; b_r = n_r;
        apb_xfer(1'b0, 4'h9, 32'h0, 4'h0, 3'b000, lat, rd, err, prdy, prd);
        check("to_latency", 32'(lat), 32'd17);
        check("to_pslverr", 32'(err), 32'd1);
        check("to_prdata", rd, 32'd0);
        check("to_arvalid_held", 32'(ARVALID), 32'd1);
        ar_delay = 0;
        for (int i = 0; i < 50 && (n_r == b_r); i++) tick();
        check("to_drain_hs_count", 32'((n_ar - b_ar) + 10 * (n_r - b_r)), 32'd11);
        tick();
        apb_xfer(1'b1, 4'h1, 32'h5A5A5A5A, 4'hF, 3'b000, lat, rd, err, prdy, prd);
        check("to_next_latency", 32'(lat), 32'd3);
        check("to_next_pslverr", 32'(err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
